udma_lin_tx_chan: RTL and testbench
===================================

Name: udma_lin_tx_chan

Overview:
- Channel-side engine for one uDMA linear TX channel; the responder end of the peripheral TX data request/grant and valid/ready protocol.
- Holds a single L2 read buffer descriptor and generates addresses, grants and data for peripheral read requests.
- Fetches data from L2 over a req/gnt/rvalid port.
- Sits in the uDMA core between the L2 read arbiter and one peripheral's TX channel (e.g. the UART transmitter).

Parameters:
- L2_AWIDTH_NOAL, 19: byte address width of L2 buffers.
- TRANS_SIZE, 20: width of transfer size and bytes-left counters.

Ports:
- sys_clk_i  in  1  single clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- cfg_startaddr_i  in  L2_AWIDTH_NOAL  buffer start byte address.
- cfg_size_i  in  TRANS_SIZE  buffer length in bytes.
- cfg_continuous_i  in  1  reload descriptor at end of buffer.
- cfg_en_i  in  1  one-cycle pulse: start or queue a transfer.
- cfg_clr_i  in  1  one-cycle pulse: abort and flush.
- cfg_en_o  out  1  transfer active.
- cfg_pending_o  out  1  second descriptor queued.
- cfg_curr_addr_o  out  L2_AWIDTH_NOAL  next byte address.
- cfg_bytes_left_o  out  TRANS_SIZE  bytes remaining.
- data_tx_req_i  in  1  peripheral request for one item.
- data_tx_gnt_o  out  1  request accepted.
- data_tx_datasize_i  in  2  item size: 0=byte, 1=half, 2/3=word.
- data_tx_o  out  32  right-aligned, zero-extended item.
- data_tx_valid_o  out  1  data_tx_o valid.
- data_tx_ready_i  in  1  peripheral accepts data.
- l2_req_o  out  1  L2 read request.
- l2_gnt_i  in  1  L2 request accepted.
- l2_addr_o  out  32  word-aligned L2 address ({addr[..:2],2'b00}, zero-extended).
- l2_rvalid_i  in  1  L2 read data valid.
- l2_rdata_i  in  32  L2 read word.
- evt_eot_o  out  1  one-cycle end-of-transfer pulse.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, REQ, RSP, OUT.
- IDLE:
  - cfg_en_i loads curr_addr=startaddr and bytes_left=size, sets cfg_en_o, goes to REQ.
  - cfg_en_i with size=0 is ignored.
- REQ:
  - When data_tx_req_i=1 and cfg_en_o=1, assert l2_req_o combinationally with l2_addr_o from curr_addr.
  - On l2_gnt_i, assert data_tx_gnt_o in the same cycle, latch datasize and addr[1:0], go to RSP.
  - Also on l2_gnt_i, advance curr_addr by 1/2/4 and set bytes_left = bytes_left minus the item size, saturating at 0.
- RSP: on l2_rvalid_i, data_tx_o = (l2_rdata_i >> 8*addr[1:0]) masked to 8/16/32 bits; assert data_tx_valid_o; go to OUT.
- OUT:
  - Hold data stable until data_tx_valid_o & data_tx_ready_i.
  - Then go to REQ if cfg_en_o=1, else IDLE.
- One L2 transaction outstanding at most. Minimum latency from gnt to valid is one cycle after rvalid (rvalid is registered into the data register).
- End of buffer, evaluated when bytes_left reaches 0 at grant:
  - pulse evt_eot_o once.
  - If cfg_pending_o=1, reload from the stored queued descriptor and clear pending.
  - Else if cfg_continuous_i=1, reload from the current cfg inputs.
  - Otherwise clear cfg_en_o. The in-flight item still completes through RSP/OUT.
- cfg_en_i while cfg_en_o=1:
  - Stores startaddr/size/continuous into the pending slot and sets cfg_pending_o.
  - A second cfg_en_i while pending overwrites the slot.
- cfg_clr_i, highest priority:
  - Clears cfg_en_o, pending, bytes_left and curr_addr.
  - In REQ or OUT: go to IDLE immediately; data_tx_valid_o drops.
  - In RSP: go to a drain condition that waits for l2_rvalid_i, discards the data, then goes to IDLE. No gnt or valid is issued while draining.
  - cfg_en_i in the same cycle as cfg_clr_i is ignored.
- Wrap-around: curr_addr wraps modulo 2^L2_AWIDTH_NOAL.
- Misaligned half/word items that cross a 32-bit boundary are not supported. Only bytes inside the addressed word are returned; the upper bytes are 0.
- Asynchronous reset mid-transfer discards everything. After release, the block waits for a new cfg_en_i.

Decomposition:
- In udma_pkg:
  - datasize encoding constants DS_BYTE/DS_HALF/DS_WORD.
  - FSM state enum type.
  - TRANS_SIZE and L2_AWIDTH_NOAL.
- One sub-module, udma_lin_addrgen:
  - holds the descriptor, pending slot, curr_addr/bytes_left update and end-of-transfer logic.
  - the top module holds the FSM, L2 port and data alignment.

Test Plan:
- Byte stream:
  - Stimulus: startaddr=0x100, size=4, datasize=0; L2 word at 0x100 = 0xDDCCBBAA; peripheral always ready.
  - Response: data 0xAA, 0xBB, 0xCC, 0xDD; each l2_addr_o=0x100; bytes_left 3,2,1,0; one evt_eot_o; cfg_en_o falls.
- Word stream with L2 stall:
  - Stimulus: size=8, datasize=2; l2_gnt_i delayed 3 cycles; rvalid delayed 2 cycles.
  - Response: data_tx_gnt_o coincides with l2_gnt_i; two words; no extra gnt while in RSP.
- Pending descriptor:
  - Stimulus: second cfg_en_i (start 0x200, size 2) during the first transfer.
  - Response: pending=1; after the first EOT, addresses continue at 0x200; pending clears; two EOT pulses.
- Continuous mode:
  - Stimulus: size=2, datasize=1, continuous=1.
  - Response: after EOT, curr_addr returns to start; cfg_en_o stays 1.
- Clear in RSP:
  - Stimulus: cfg_clr_i pulsed while an L2 read is outstanding.
  - Response: no data_tx_valid_o; rvalid consumed silently; FSM returns to IDLE; all cfg outputs 0.
- Backpressure:
  - Stimulus: data_tx_ready_i held low 5 cycles.
  - Response: data_tx_o and data_tx_valid_o stable; no new l2_req_o until the handshake completes.

Source files
------------

// File: rtl/udma_pkg.sv
// rtl/udma_pkg.sv - shared constants, types and helpers for the uDMA linear channels
package udma_pkg;

  localparam int L2_AWIDTH_NOAL = 19;
  localparam int TRANS_SIZE     = 20;

  localparam logic [1:0] DS_BYTE = 2'd0;
  localparam logic [1:0] DS_HALF = 2'd1;
  localparam logic [1:0] DS_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_OUT  = 2'd3
  } tx_state_t;

  // Bytes consumed by one item; encodings 2 and 3 both mean a word.
  function automatic logic [2:0] item_bytes(input logic [1:0] ds);
    logic [2:0] n;
    case (ds)
      DS_BYTE: n = 3'd1;
      DS_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Right-align the addressed bytes of an L2 word and zero the unused upper bits.
  function automatic logic [31:0] align_item(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [1:0]  ds);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (ds)
      DS_BYTE: res = {24'h0, sh[7:0]};
      DS_HALF: res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/udma_lin_addrgen.sv
// rtl/udma_lin_addrgen.sv - descriptor, pending slot and address/bytes-left bookkeeping
module udma_lin_addrgen #(
  parameter int L2_AWIDTH_NOAL = udma_pkg::L2_AWIDTH_NOAL,
  parameter int TRANS_SIZE     = udma_pkg::TRANS_SIZE
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic                      advance_i,
  input  logic [1:0]                datasize_i,
  output logic                      en_o,
  output logic                      pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] curr_addr_o,
  output logic [TRANS_SIZE-1:0]     bytes_left_o,
  output logic                      eot_o
);

  import udma_pkg::*;

  logic [L2_AWIDTH_NOAL-1:0] curr_addr;
  logic [L2_AWIDTH_NOAL-1:0] pend_addr;
  logic [TRANS_SIZE-1:0]     bytes_left;
  logic [TRANS_SIZE-1:0]     pend_size;
  logic                      en;
  logic                      pending;
  logic                      eot;

  logic [2:0]                step;
  logic [L2_AWIDTH_NOAL-1:0] next_addr;
  logic [TRANS_SIZE-1:0]     next_left;
  logic                      start_ok;
  logic                      last_item;

  // Next address wraps naturally at the address width; bytes left saturates at zero.
  always_comb begin
    step      = item_bytes(datasize_i);
    next_addr = curr_addr + L2_AWIDTH_NOAL'(step);
    next_left = (bytes_left > TRANS_SIZE'(step)) ? (bytes_left - TRANS_SIZE'(step)) : '0;
    start_ok  = cfg_en_i && (cfg_size_i != '0);
    last_item = (next_left == '0);
  end

  // Descriptor state: clear wins, then grant-driven advance/reload, then new starts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      curr_addr  <= '0;
      bytes_left <= '0;
      pend_addr  <= '0;
      pend_size  <= '0;
      en         <= 1'b0;
      pending    <= 1'b0;
      eot        <= 1'b0;
    end else begin
      eot <= 1'b0;
      if (cfg_clr_i) begin
        en         <= 1'b0;
        pending    <= 1'b0;
        bytes_left <= '0;
        curr_addr  <= '0;
      end else if (advance_i && en) begin
        if (last_item) begin
          eot <= 1'b1;
          if (pending) begin
            curr_addr  <= pend_addr;
            bytes_left <= pend_size;
            pending    <= 1'b0;
            if (start_ok) begin
              // A start arriving on the very reload cycle refills the slot.
              pend_addr <= cfg_startaddr_i;
              pend_size <= cfg_size_i;
              pending   <= 1'b1;
            end
          end else if (start_ok || cfg_continuous_i) begin
            // A start landing on the final grant is taken directly rather than queued.
            curr_addr  <= cfg_startaddr_i;
            bytes_left <= cfg_size_i;
          end else begin
            en         <= 1'b0;
            curr_addr  <= next_addr;
            bytes_left <= '0;
          end
        end else begin
          curr_addr  <= next_addr;
          bytes_left <= next_left;
          if (start_ok) begin
            pend_addr <= cfg_startaddr_i;
            pend_size <= cfg_size_i;
            pending   <= 1'b1;
          end
        end
      end else if (start_ok) begin
        if (en) begin
          pend_addr <= cfg_startaddr_i;
          pend_size <= cfg_size_i;
          pending   <= 1'b1;
        end else begin
          curr_addr  <= cfg_startaddr_i;
          bytes_left <= cfg_size_i;
          en         <= 1'b1;
        end
      end
    end
  end

  assign en_o         = en;
  assign pending_o    = pending;
  assign curr_addr_o  = curr_addr;
  assign bytes_left_o = bytes_left;
  assign eot_o        = eot;

endmodule

// File: rtl/udma_lin_tx_chan.sv
// rtl/udma_lin_tx_chan.sv - uDMA linear TX channel: peripheral responder and L2 read engine
module udma_lin_tx_chan #(
  parameter int L2_AWIDTH_NOAL = udma_pkg::L2_AWIDTH_NOAL,
  parameter int TRANS_SIZE     = udma_pkg::TRANS_SIZE
) (
  input  logic                      sys_clk_i,
  input  logic                      rstn_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  input  logic                      data_tx_req_i,
  output logic                      data_tx_gnt_o,
  input  logic [1:0]                data_tx_datasize_i,
  output logic [31:0]               data_tx_o,
  output logic                      data_tx_valid_o,
  input  logic                      data_tx_ready_i,
  output logic                      l2_req_o,
  input  logic                      l2_gnt_i,
  output logic [31:0]               l2_addr_o,
  input  logic                      l2_rvalid_i,
  input  logic [31:0]               l2_rdata_i,
  output logic                      evt_eot_o
);

  import udma_pkg::*;

  tx_state_t   state;
  logic        drain;
  logic [1:0]  lat_ds;
  logic [1:0]  lat_off;
  logic [31:0] data_q;
  logic        valid_q;
  logic        l2_req;
  logic        tx_gnt;
  logic [31:0] aligned;

  udma_lin_addrgen #(
    .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
    .TRANS_SIZE     (TRANS_SIZE)
  ) u_addrgen (
    .clk_i            (sys_clk_i),
    .rstn_i           (rstn_i),
    .cfg_startaddr_i  (cfg_startaddr_i),
    .cfg_size_i       (cfg_size_i),
    .cfg_continuous_i (cfg_continuous_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_clr_i        (cfg_clr_i),
    .advance_i        (tx_gnt),
    .datasize_i       (data_tx_datasize_i),
    .en_o             (cfg_en_o),
    .pending_o        (cfg_pending_o),
    .curr_addr_o      (cfg_curr_addr_o),
    .bytes_left_o     (cfg_bytes_left_o),
    .eot_o            (evt_eot_o)
  );

  // The L2 request follows the peripheral request combinationally so the grant can pass straight back.
  always_comb begin
    l2_req  = (state == ST_REQ) && data_tx_req_i && cfg_en_o && !cfg_clr_i;
    tx_gnt  = l2_req && l2_gnt_i;
    aligned = align_item(l2_rdata_i, lat_off, lat_ds);
  end

  // Channel FSM: one L2 read in flight, data held in OUT until the peripheral takes it.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= ST_IDLE;
      drain   <= 1'b0;
      lat_ds  <= 2'd0;
      lat_off <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cfg_clr_i && (cfg_en_o || (cfg_en_i && (cfg_size_i != '0)))) begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cfg_clr_i) begin
            state <= ST_IDLE;
          end else if (tx_gnt) begin
            lat_ds  <= data_tx_datasize_i;
            lat_off <= cfg_curr_addr_o[1:0];
            state   <= ST_RSP;
          end
        end
        ST_RSP: begin
          // A clear cannot cancel the L2 read, so remember to swallow its response.
          if (cfg_clr_i) begin
            drain <= 1'b1;
          end
          if (l2_rvalid_i) begin
            if (drain || cfg_clr_i) begin
              drain <= 1'b0;
              state <= ST_IDLE;
            end else begin
              data_q  <= aligned;
              valid_q <= 1'b1;
              state   <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (cfg_clr_i) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end else if (data_tx_ready_i) begin
            valid_q <= 1'b0;
            state   <= cfg_en_o ? ST_REQ : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_tx_gnt_o   = tx_gnt;
  assign data_tx_o       = data_q;
  assign data_tx_valid_o = valid_q;
  assign l2_req_o        = l2_req;
  assign l2_addr_o       = 32'({cfg_curr_addr_o[L2_AWIDTH_NOAL-1:2], 2'b00});

endmodule

// File: tb/tb_udma_lin_tx_chan.sv
// tb/tb_udma_lin_tx_chan.sv - self-checking bench for the uDMA linear TX channel
module tb_udma_lin_tx_chan;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [18:0] cfg_startaddr = '0;
  logic [19:0] cfg_size = '0;
  logic        cfg_cont = 1'b0;
  logic        cfg_en = 1'b0;
  logic        cfg_clr = 1'b0;
  logic        cfg_en_o;
  logic        cfg_pending_o;
  logic [18:0] cfg_curr_addr_o;
  logic [19:0] cfg_bytes_left_o;
  logic        tx_req = 1'b0;
  logic        data_tx_gnt_o;
  logic [1:0]  tx_ds = 2'd0;
  logic [31:0] data_tx_o;
  logic        data_tx_valid_o;
  logic        tx_ready = 1'b1;
  logic        l2_req_o;
  logic        l2_gnt = 1'b0;
  logic [31:0] l2_addr_o;
  logic        l2_rvalid = 1'b0;
  logic [31:0] l2_rdata = '0;
  logic        evt_eot_o;

  int n_checks = 0;
  int n_fail = 0;
  int eot_cnt = 0;
  int gnt_cnt = 0;
  int valid_cyc = 0;
  int gnt_dly = 0;
  int rv_dly = 0;

  always #5 clk = ~clk;

  udma_lin_tx_chan dut (
    .sys_clk_i          (clk),
    .rstn_i             (rstn),
    .cfg_startaddr_i    (cfg_startaddr),
    .cfg_size_i         (cfg_size),
    .cfg_continuous_i   (cfg_cont),
    .cfg_en_i           (cfg_en),
    .cfg_clr_i          (cfg_clr),
    .cfg_en_o           (cfg_en_o),
    .cfg_pending_o      (cfg_pending_o),
    .cfg_curr_addr_o    (cfg_curr_addr_o),
    .cfg_bytes_left_o   (cfg_bytes_left_o),
    .data_tx_req_i      (tx_req),
    .data_tx_gnt_o      (data_tx_gnt_o),
    .data_tx_datasize_i (tx_ds),
    .data_tx_o          (data_tx_o),
    .data_tx_valid_o    (data_tx_valid_o),
    .data_tx_ready_i    (tx_ready),
    .l2_req_o           (l2_req_o),
    .l2_gnt_i           (l2_gnt),
    .l2_addr_o          (l2_addr_o),
    .l2_rvalid_i        (l2_rvalid),
    .l2_rdata_i         (l2_rdata),
    .evt_eot_o          (evt_eot_o)
  );

  function automatic logic [31:0] l2_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDDCCBBAA;
      32'h104: return 32'h11223344;
      32'h108: return 32'h55667788;
      32'h200: return 32'hCAFEF00D;
      32'h300: return 32'h87654321;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // L2 slave: grant after gnt_dly waiting cycles, data rv_dly cycles after the grant cycle
  initial begin : l2_model
    int gcnt;
    int rcnt;
    bit busy;
    logic [31:0] a;
    gcnt = 0; rcnt = 0; busy = 0; a = '0;
    forever begin
      @(posedge clk); #2;
      l2_gnt = 1'b0;
      l2_rvalid = 1'b0;
      if (!rstn) begin
        busy = 0; gcnt = 0;
      end else if (busy) begin
        if (rcnt == 0) begin
          l2_rvalid = 1'b1;
          l2_rdata = l2_word(a);
          busy = 0;
        end else rcnt--;
      end else if (l2_req_o) begin
        if (gcnt >= gnt_dly) begin
          l2_gnt = 1'b1; a = l2_addr_o; busy = 1; rcnt = rv_dly; gcnt = 0;
        end else gcnt++;
      end else gcnt = 0;
    end
  end

  // Protocol monitor: grant passthrough, no L2 request while data is held, event counters
  always @(negedge clk) begin
    if (rstn) begin
      if (evt_eot_o) eot_cnt++;
      if (data_tx_gnt_o) gnt_cnt++;
      if (data_tx_valid_o) valid_cyc++;
      if (data_tx_gnt_o || l2_gnt) begin
        n_checks++;
        if (data_tx_gnt_o !== l2_gnt) begin
          n_fail++;
          $display("FAIL gnt_passthru: data_tx_gnt_o=%b l2_gnt=%b", data_tx_gnt_o, l2_gnt);
        end
      end
      if (data_tx_valid_o) begin
        n_checks++;
        if (l2_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL req_while_valid: l2_req_o=%b, expected 0", l2_req_o);
        end
      end
    end
  end

  task automatic cfg_start(input logic [31:0] a, input logic [19:0] s, input bit c);
    @(posedge clk); #1;
    cfg_startaddr = a[18:0]; cfg_size = s; cfg_cont = c; cfg_en = 1'b1;
    @(posedge clk); #1;
    cfg_en = 1'b0;
  endtask

  // One peripheral item: request, wait grant, wait data, optional backpressure, handshake
  task automatic xfer_item(input logic [1:0] ds, input int hold,
                           output logic [31:0] data, output logic [31:0] laddr);
    int n;
    data = '0; laddr = '0;
    @(posedge clk); #1;
    tx_req = 1'b1; tx_ds = ds;
    if (hold > 0) tx_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_tx_gnt_o && n < 64);
    chk("gnt_seen", data_tx_gnt_o, 1);
    laddr = l2_addr_o;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_tx_valid_o && n < 64);
    chk("valid_seen", data_tx_valid_o, 1);
    data = data_tx_o;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bp_valid_stable", data_tx_valid_o, 1);
      chk("bp_data_stable", data_tx_o, data);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      tx_ready = 1'b1;
    end
    @(posedge clk); #1;
    tx_req = 1'b0;
  endtask

  typedef struct {
    bit          start;
    logic [31:0] saddr;
    logic [19:0] ssize;
    bit          cont;
    bit          queue;
    logic [31:0] qaddr;
    logic [19:0] qsize;
    int          gdly;
    int          rdly;
    logic [1:0]  ds;
    logic [31:0] e_data;
    logic [31:0] e_laddr;
    logic [31:0] e_curr;
    logic [19:0] e_left;
    bit          e_en;
    bit          e_pend;
    int          e_eot;
  } vec_t;

  vec_t tbl[11];

  initial begin : main
    logic [31:0] d;
    logic [31:0] la;
    int g0;
    int v0;
    int n;

    tbl[0]  = '{1'b1, 32'h100, 20'd4, 1'b0, 1'b0, 32'h0, 20'd0, 0, 0, 2'd0, 32'hAA,       32'h100, 32'h101, 20'd3, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 32'h0,   20'd0, 1'b0, 1'b0, 32'h0, 20'd0, 0, 0, 2'd0, 32'hBB,       32'h100, 32'h102, 20'd2, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 32'h0,   20'd0, 1'b0, 1'b0, 32'h0, 20'd0, 0, 0, 2'd0, 32'hCC,       32'h100, 32'h103, 20'd1, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 32'h0,   20'd0, 1'b0, 1'b0, 32'h0, 20'd0, 0, 0, 2'd0, 32'hDD,       32'h100, 32'h104, 20'd0, 1'b0, 1'b0, 1};
    tbl[4]  = '{1'b1, 32'h104, 20'd8, 1'b0, 1'b0, 32'h0, 20'd0, 3, 2, 2'd2, 32'h11223344, 32'h104, 32'h108, 20'd4, 1'b1, 1'b0, 1};
    tbl[5]  = '{1'b0, 32'h0,   20'd0, 1'b0, 1'b0, 32'h0, 20'd0, 3, 2, 2'd2, 32'h55667788, 32'h108, 32'h10C, 20'd0, 1'b0, 1'b0, 2};
    tbl[6]  = '{1'b1, 32'h100, 20'd2, 1'b0, 1'b1, 32'h200, 20'd2, 0, 0, 2'd0, 32'hAA,     32'h100, 32'h101, 20'd1, 1'b1, 1'b1, 2};
    tbl[7]  = '{1'b0, 32'h0,   20'd0, 1'b0, 1'b0, 32'h0, 20'd0, 0, 0, 2'd0, 32'hBB,       32'h100, 32'h200, 20'd2, 1'b1, 1'b0, 3};
    tbl[8]  = '{1'b0, 32'h0,   20'd0, 1'b0, 1'b0, 32'h0, 20'd0, 0, 0, 2'd1, 32'hF00D,     32'h200, 32'h202, 20'd0, 1'b0, 1'b0, 4};
    tbl[9]  = '{1'b1, 32'h302, 20'd2, 1'b1, 1'b0, 32'h0, 20'd0, 0, 0, 2'd1, 32'h8765,     32'h300, 32'h302, 20'd2, 1'b1, 1'b0, 5};
    tbl[10] = '{1'b0, 32'h0,   20'd0, 1'b0, 1'b0, 32'h0, 20'd0, 0, 0, 2'd1, 32'h8765,     32'h300, 32'h302, 20'd2, 1'b1, 1'b0, 6};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst cfg_en_o", cfg_en_o, 0);
    chk("rst pending", cfg_pending_o, 0);
    chk("rst curr_addr", cfg_curr_addr_o, 0);
    chk("rst bytes_left", cfg_bytes_left_o, 0);
    chk("rst data_tx_o", data_tx_o, 0);
    chk("rst valid", data_tx_valid_o, 0);
    chk("rst l2_req", l2_req_o, 0);
    chk("rst l2_addr", l2_addr_o, 0);
    chk("rst eot", evt_eot_o, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // byte stream, stalled word stream, pending descriptor, continuous mode
    for (int i = 0; i < 11; i++) begin
      gnt_dly = tbl[i].gdly;
      rv_dly  = tbl[i].rdly;
      if (tbl[i].start) cfg_start(tbl[i].saddr, tbl[i].ssize, tbl[i].cont);
      g0 = gnt_cnt;
      xfer_item(tbl[i].ds, 0, d, la);
      if (tbl[i].queue) cfg_start(tbl[i].qaddr, tbl[i].qsize, 1'b0);
      chk($sformatf("v%0d data", i), d, tbl[i].e_data);
      chk($sformatf("v%0d l2_addr", i), la, tbl[i].e_laddr);
      chk($sformatf("v%0d curr_addr", i), 32'(cfg_curr_addr_o), tbl[i].e_curr);
      chk($sformatf("v%0d bytes_left", i), 32'(cfg_bytes_left_o), 32'(tbl[i].e_left));
      chk($sformatf("v%0d cfg_en", i), cfg_en_o, tbl[i].e_en);
      chk($sformatf("v%0d pending", i), cfg_pending_o, tbl[i].e_pend);
      chk($sformatf("v%0d eot_count", i), eot_cnt, tbl[i].e_eot);
      chk($sformatf("v%0d one_gnt", i), gnt_cnt - g0, 1);
    end

    // clear while an L2 read is outstanding; queue a descriptor first so pending is set
    cfg_start(32'h200, 20'd2, 1'b0);
    chk("clr pre pending", cfg_pending_o, 1);
    gnt_dly = 0; rv_dly = 4;
    g0 = gnt_cnt; v0 = valid_cyc;
    @(posedge clk); #1;
    tx_req = 1'b1; tx_ds = 2'd0;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_tx_gnt_o && n < 64);
    chk("clr gnt_seen", data_tx_gnt_o, 1);
    @(posedge clk); #1;
    cfg_clr = 1'b1; cfg_en = 1'b1; cfg_startaddr = 19'h104; cfg_size = 20'd4;
    @(posedge clk); #1;
    cfg_clr = 1'b0; cfg_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("clr no_valid", valid_cyc - v0, 0);
    chk("clr no_extra_gnt", gnt_cnt - g0, 1);
    chk("clr cfg_en", cfg_en_o, 0);
    chk("clr pending", cfg_pending_o, 0);
    chk("clr curr_addr", cfg_curr_addr_o, 0);
    chk("clr bytes_left", cfg_bytes_left_o, 0);
    chk("clr l2_req", l2_req_o, 0);
    tx_req = 1'b0;

    // zero-size start is ignored
    rv_dly = 0;
    cfg_start(32'h104, 20'd0, 1'b0);
    tx_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("size0 cfg_en", cfg_en_o, 0);
    chk("size0 l2_req", l2_req_o, 0);
    tx_req = 1'b0;

    // backpressure: data held for 5 cycles, no new L2 request meanwhile
    g0 = gnt_cnt; v0 = eot_cnt;
    cfg_start(32'h104, 20'd4, 1'b0);
    xfer_item(2'd2, 5, d, la);
    chk("bp data", d, 32'h11223344);
    chk("bp l2_addr", la, 32'h104);
    chk("bp one_gnt", gnt_cnt - g0, 1);
    chk("bp eot", eot_cnt - v0, 1);
    chk("bp cfg_en", cfg_en_o, 0);
    chk("bp curr_addr", cfg_curr_addr_o, 32'h108);
    @(negedge clk);
    chk("bp valid_dropped", data_tx_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
